// File: rtl/ql_bus_master.sv
// ---------------------------------------------------------------------------
// ql_bus_master
//
// 68008-style bus-cycle initiator for the QL expansion bus. A host-side
// command (req/wr/addr/wdata) launches one byte read or write cycle on the
// bus (address, asl, dsl, rdwl, data). The cycle ends when the slave
// acknowledges on dtackl or when the acknowledge wait times out.
//
// Cycle shape:
//   IDLE -> SETUP -> STROBE -> WAIT -> TERM -> HOLD -> IDLE
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   req           command strobe, accepted only while ready=1
//   wr            1 = write cycle, 0 = read cycle (sampled with req)
//   addr          cycle address (sampled with req)
//   wdata         write data (sampled with req)
//   ready         idle, a req will be accepted on this edge
//   done          one-clock pulse when a cycle ends (normal or error)
//   berr          valid with done: 1 = dtackl timeout
//   rdata         read data, updated only by a successful read
//   address       bus address, valid while addr_oe=1
//   addr_oe       address/control output enable
//   asl, dsl      address and data strobes, active low
//   rdwl          1 = read, 0 = write
//   data_out      bus write data
//   data_oe       bus data output enable (write cycles only)
//   data_in       bus read data
//   dtackl        slave acknowledge, active low, asynchronous to clk
// ---------------------------------------------------------------------------
module ql_bus_master #(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              berr,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address,
  output logic              addr_oe,
  output logic              asl,
  output logic              dsl,
  output logic              rdwl,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dtackl
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_TERM   = 3'd4;
  localparam logic [2:0] S_HOLD   = 3'd5;

  // Terminal values of the shared phase counter. The counter starts at 0 on
  // entry to each timed phase, so the phase ends when it holds N-1.
  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       wr_q;

  // dtackl synchronizer: dtk_p0 is the metastability stage, dtk_s the
  // usable acknowledge.
  logic       dtk_p0;
  logic       dtk_s;

  logic       accept;
  logic       setup_end;
  logic       wait_ack;
  logic       wait_to;
  logic       hold_end;

  assign ready = (state == S_IDLE);

  // Cycle events. The acknowledge wins over a timeout landing on the same
  // edge, so a slave answering in the last WAIT clock is still a success.
  always_comb begin
    accept    = (state == S_IDLE)  && req;
    setup_end = (state == S_SETUP) && (cnt == SETUP_LAST);
    wait_ack  = (state == S_WAIT)  && !dtk_s;
    wait_to   = (state == S_WAIT)  &&  dtk_s && (cnt == TO_LAST);
    hold_end  = (state == S_HOLD)  && (cnt == HOLD_LAST);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_SETUP;
          cnt_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (setup_end) begin
          state_nxt = S_STROBE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_STROBE: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        if (wait_ack || wait_to) begin
          state_nxt = S_TERM;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_TERM: begin
        state_nxt = S_HOLD;
        cnt_nxt   = '0;
      end
      S_HOLD: begin
        if (hold_end) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- state / phase counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---- dtackl synchronizer ----
  // Only clocked while waiting: an acknowledge left asserted from before
  // the strobes (or stuck low) is not seen until two WAIT clocks in, and
  // the flops are re-armed to "negated" in every other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dtk_p0 <= 1'b1;
      dtk_s  <= 1'b1;
    end else if (state == S_WAIT) begin
      dtk_p0 <= dtackl;
      dtk_s  <= dtk_p0;
    end else begin
      dtk_p0 <= 1'b1;
      dtk_s  <= 1'b1;
    end
  end

  // ---- command latch: address, write data, direction ----
  // Held after the cycle so the bus lines do not toggle while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address  <= '0;
      data_out <= '0;
      wr_q     <= 1'b0;
    end else if (accept) begin
      address  <= addr;
      data_out <= wdata;
      wr_q     <= wr;
    end
  end

  // ---- address/control enables ----
  // rdwl and data_oe change only together with addr_oe, so data_oe=1 can
  // never coincide with rdwl=1 and the strobes always sit inside addr_oe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_oe <= 1'b0;
      rdwl    <= 1'b1;
      data_oe <= 1'b0;
    end else if (accept) begin
      addr_oe <= 1'b1;
      rdwl    <= ~wr;
      data_oe <= wr;
    end else if (hold_end) begin
      addr_oe <= 1'b0;
      rdwl    <= 1'b1;
      data_oe <= 1'b0;
    end
  end

  // ---- strobes ----
  // Reads drop dsl with asl; writes drop dsl one clock later so the data
  // has been on the bus for a full clock first. Both rise together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asl <= 1'b1;
      dsl <= 1'b1;
    end else if (setup_end) begin
      asl <= 1'b0;
      if (!wr_q) begin
        dsl <= 1'b0;
      end
    end else if ((state == S_STROBE) && wr_q) begin
      dsl <= 1'b0;
    end else if (wait_ack || wait_to) begin
      asl <= 1'b1;
      dsl <= 1'b1;
    end
  end

  // ---- completion status and read data ----
  // done/berr are set on the WAIT exit edge and therefore last exactly the
  // single TERM clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      berr  <= 1'b0;
      rdata <= '0;
    end else begin
      done <= wait_ack || wait_to;
      berr <= wait_to;
      if (wait_ack && !wr_q) begin
        rdata <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_ql_bus_master.sv
module tb_ql_bus_master;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 8;
  localparam int SETUP_CYC = 1;
  localparam int HOLD_CYC  = 1;
  localparam int TIMEOUT   = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req = 1'b0;
  logic              wr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              dtackl = 1'b1;
  logic              ready;
  logic              done;
  logic              berr;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address;
  logic              addr_oe;
  logic              asl;
  logic              dsl;
  logic              rdwl;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;

  ql_bus_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYC(SETUP_CYC),
    .HOLD_CYC(HOLD_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .berr(berr), .rdata(rdata),
    .address(address), .addr_oe(addr_oe), .asl(asl), .dsl(dsl),
    .rdwl(rdwl), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .dtackl(dtackl)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Slave model: acknowledges slv_delay clocks after it first sees asl low,
  // never acknowledges when slv_to is set, and holds dtackl low all the time
  // when slv_pre is set. dtackl is released as soon as asl is seen high.
  int              slv_delay = 0;
  bit              slv_to = 1'b0;
  bit              slv_pre = 1'b0;
  logic [DATA_W-1:0] slv_din = '0;

  initial begin
    int asl_cnt;
    asl_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      data_in = slv_din;
      if (asl === 1'b0) begin
        if (!slv_to && asl_cnt >= slv_delay) dtackl = 1'b0;
        asl_cnt++;
      end else begin
        asl_cnt = 0;
        dtackl  = slv_pre ? 1'b0 : 1'b1;
      end
    end
  end

  // Reference model. Edges are counted from the edge that accepts req.
  // asl falls SETUP_CYC edges later and WAIT starts one edge after that.
  // The acknowledge is only looked at inside WAIT, it is first usable k WAIT
  // clocks in (k>=1, k=D when the slave answers D clocks after asl falls),
  // and two synchronizer clocks later the cycle terminates. Otherwise the
  // cycle is cut after TIMEOUT WAIT clocks.
  function automatic int ack_k(input bit pre, input int d);
    if (pre || d < 1) return 1;
    return d;
  endfunction

  function automatic bit model_berr(input bit to, input bit pre, input int d);
    return to || (ack_k(pre, d) + 2 > TIMEOUT);
  endfunction

  function automatic int model_latency(input bit to, input bit pre, input int d);
    if (model_berr(to, pre, d)) return SETUP_CYC + 1 + TIMEOUT;
    return SETUP_CYC + 1 + ack_k(pre, d) + 2;
  endfunction

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                d;
    bit                to;
    bit                pre;
    logic [DATA_W-1:0] din;
    bit                e_berr;
    logic [DATA_W-1:0] e_rdata;
    int                e_lat;
  } vec_t;

  logic [DATA_W-1:0] model_rdata;

  // Runs one command from an idle bus, watching every clock until addr_oe
  // drops, and checks the observed cycle against the vector.
  task automatic run_txn(input vec_t v, input string tag);
    int n, asl_f, dsl_f, done_e, ndone, drop, bad;
    logic b_at, neg_at;
    logic [DATA_W-1:0] r_at;
    slv_delay = v.d;
    slv_to    = v.to;
    slv_pre   = v.pre;
    slv_din   = v.din;
    chk({tag, "/ready_before"}, int'(ready), 1);
    req = 1'b1; wr = v.wr; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1;
    req = 1'b0; wr = ~v.wr; addr = ~v.addr; wdata = ~v.wdata;
    n = 0; asl_f = -1; dsl_f = -1; done_e = -1; ndone = 0; drop = -1; bad = 0;
    b_at = 1'b0; neg_at = 1'b0; r_at = '0;
    while (drop < 0 && n < 400) begin
      if (asl === 1'b0 && asl_f < 0) asl_f = n;
      if (dsl === 1'b0 && dsl_f < 0) dsl_f = n;
      if (done === 1'b1) begin
        ndone++;
        if (done_e < 0) begin
          done_e = n; b_at = berr; r_at = rdata; neg_at = asl & dsl;
        end
      end
      if ((asl === 1'b0 && addr_oe !== 1'b1) || (dsl === 1'b0 && asl !== 1'b0) ||
          (data_oe === 1'b1 && rdwl !== 1'b0)) bad++;
      if (addr_oe === 1'b1) begin
        if (address !== v.addr || rdwl !== ~v.wr || data_oe !== v.wr || ready !== 1'b0 ||
            (v.wr && data_out !== v.wdata)) bad++;
      end else begin
        drop = n;
      end
      if (drop < 0) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk({tag, "/cycle_ends"}, int'(drop >= 0), 1);
    chk({tag, "/asl_fall_edge"}, asl_f, SETUP_CYC);
    chk({tag, "/dsl_fall_edge"}, dsl_f, SETUP_CYC + (v.wr ? 1 : 0));
    chk({tag, "/done_edge"}, done_e, v.e_lat);
    chk({tag, "/done_pulses"}, ndone, 1);
    chk({tag, "/berr"}, int'(b_at), int'(v.e_berr));
    chk({tag, "/rdata"}, int'(r_at), int'(v.e_rdata));
    chk({tag, "/strobes_negated_at_done"}, int'(neg_at), 1);
    chk({tag, "/addr_oe_drop_edge"}, drop, v.e_lat + 1 + HOLD_CYC);
    chk({tag, "/bus_stable"}, bad, 0);
    chk({tag, "/ready_after"}, int'(ready), 1);
    slv_pre = 1'b0;
    slv_to  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    int fall_e[3];
    int done_e[3];
    int nf, nd, bad;
    logic prev_asl;

    // wr  addr       wdata  d    to  pre din    berr rdata  latency
    tbl[0] = '{1'b0, 20'h00048, 8'h00,   3, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5,   7};
    tbl[1] = '{1'b1, 20'h00048, 8'h3C,   3, 1'b0, 1'b0, 8'h11, 1'b0, 8'hA5,   7};
    tbl[2] = '{1'b0, 20'h00049, 8'h00,   0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'h5A,   5};
    tbl[3] = '{1'b0, 20'hFFFFF, 8'h00,   0, 1'b1, 1'b0, 8'h77, 1'b1, 8'h5A, 257};
    tbl[4] = '{1'b1, 20'h80001, 8'hFF,   1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5A,   5};
    tbl[5] = '{1'b0, 20'h00000, 8'h00,  10, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00,  14};
    tbl[6] = '{1'b0, 20'h12345, 8'h00,   0, 1'b0, 1'b0, 8'hC3, 1'b0, 8'hC3,   5};
    tbl[7] = '{1'b0, 20'h7FFFF, 8'h00, 253, 1'b0, 1'b0, 8'h99, 1'b0, 8'h99, 257};
    tbl[8] = '{1'b0, 20'h7FFFE, 8'h00, 254, 1'b0, 1'b0, 8'h66, 1'b1, 8'h99, 257};
    tbl[9] = '{1'b1, 20'hABCDE, 8'h5A,   2, 1'b0, 1'b0, 8'hEE, 1'b0, 8'h99,   6};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst/ready", int'(ready), 1);
    chk("rst/done", int'(done), 0);
    chk("rst/berr", int'(berr), 0);
    chk("rst/rdata", int'(rdata), 0);
    chk("rst/address", int'(address), 0);
    chk("rst/addr_oe", int'(addr_oe), 0);
    chk("rst/asl", int'(asl), 1);
    chk("rst/dsl", int'(dsl), 1);
    chk("rst/rdwl", int'(rdwl), 1);
    chk("rst/data_out", int'(data_out), 0);
    chk("rst/data_oe", int'(data_oe), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_rdata = '0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
      model_rdata = tbl[i].e_rdata;
    end

    // Back-to-back: req held high until three cycles have completed
    slv_delay = 2; slv_to = 1'b0; slv_pre = 1'b0; slv_din = 8'h4B;
    wr = 1'b0; addr = 20'h00A00; req = 1'b1;
    nf = 0; nd = 0; bad = 0; prev_asl = 1'b1;
    for (int j = 0; j < 3; j++) begin
      fall_e[j] = -1;
      done_e[j] = -1;
    end
    for (int c = 0; c < 120; c++) begin
      @(posedge clk);
      #1;
      if (prev_asl === 1'b1 && asl === 1'b0) begin
        if (nf < 3) fall_e[nf] = c;
        nf++;
      end
      prev_asl = asl;
      if (done === 1'b1) begin
        if (nd < 3) done_e[nd] = c;
        nd++;
        if (nd == 3) req = 1'b0;
      end
      if (addr_oe === 1'b1 && ready !== 1'b0) bad++;
      if ((asl === 1'b0 && addr_oe !== 1'b1) || (dsl === 1'b0 && asl !== 1'b0) ||
          (data_oe === 1'b1 && rdwl !== 1'b0)) bad++;
    end
    req = 1'b0;
    chk("b2b/cycles_started", nf, 3);
    chk("b2b/done_pulses", nd, 3);
    chk("b2b/first_asl_fall", fall_e[0], SETUP_CYC);
    chk("b2b/first_done", done_e[0], model_latency(1'b0, 1'b0, 2));
    chk("b2b/gap1", fall_e[1] - done_e[0], 1 + HOLD_CYC + 1 + SETUP_CYC);
    chk("b2b/gap2", fall_e[2] - done_e[1], 1 + HOLD_CYC + 1 + SETUP_CYC);
    chk("b2b/ready_low_in_cycle", bad, 0);
    chk("b2b/rdata", int'(rdata), 8'h4B);
    model_rdata = 8'h4B;

    // Reset during WAIT: outputs return at once, no done, next cycle normal
    slv_to = 1'b1; slv_delay = 0;
    wr = 1'b0; addr = 20'h00B0B; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("rstwait/in_wait_asl", int'(asl), 0);
    rst = 1'b1;
    #1;
    chk("rstwait/asl", int'(asl), 1);
    chk("rstwait/dsl", int'(dsl), 1);
    chk("rstwait/addr_oe", int'(addr_oe), 0);
    chk("rstwait/rdwl", int'(rdwl), 1);
    chk("rstwait/ready", int'(ready), 1);
    #1;
    rst = 1'b0;
    slv_to = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) nd++;
    end
    chk("rstwait/no_done", nd, 0);
    chk("rstwait/rdata_cleared", int'(rdata), 0);
    model_rdata = '0;
    v = '{1'b0, 20'h00B0B, 8'h00, 1, 1'b0, 1'b0, 8'h3E, 1'b0, 8'h3E, 5};
    run_txn(v, "rstwait/next");
    model_rdata = 8'h3E;

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom_range(0, 1));
      v.addr  = ADDR_W'($urandom);
      v.wdata = DATA_W'($urandom);
      v.din   = DATA_W'($urandom);
      v.pre   = ($urandom_range(0, 5) == 0);
      v.to    = !v.pre && ($urandom_range(0, 7) == 0);
      v.d     = v.pre ? 0 : int'($urandom_range(0, 12));
      v.e_berr  = model_berr(v.to, v.pre, v.d);
      v.e_lat   = model_latency(v.to, v.pre, v.d);
      v.e_rdata = (!v.wr && !v.e_berr) ? v.din : model_rdata;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      run_txn(v, $sformatf("rnd%0d", i));
      model_rdata = v.e_rdata;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
